router_arbiter: RTL

- Shares the 4-input/4-output router crossbar among four requesters.
- Each requester raises a request and names a destination port. The arbiter picks one winner by round-robin and drives the router's sender/receiver selects.
- Holds the grant while the request stays up, for at most HOLD_CYCLES cycles, then forces a release.
- Sits between requester logic and the router instance; its sender/receiver outputs connect directly to the router's select inputs.

---
 rtl/router_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/router_arbiter.sv
// rtl/router_arbiter.sv - round-robin arbiter driving the 4x4 router crossbar selects
module router_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] dest,
    output logic [3:0] grant,
    output logic [1:0] sender,
    output logic [1:0] receiver,
    output logic       active,
    output logic       done
);

    localparam logic [7:0] HOLD = HOLD_CYCLES[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sender_q, sender_d;
    logic [1:0] receiver_q, receiver_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;
    logic [1:0] dest_sel;

    // Scan starts just after the last-released requester and ends on it.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + k[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        dest_sel = 2'd0;
        case (winner)
            2'd0: dest_sel = dest[1:0];
            2'd1: dest_sel = dest[3:2];
            2'd2: dest_sel = dest[5:4];
            2'd3: dest_sel = dest[7:6];
            default: dest_sel = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sender_d   = sender_q;
        receiver_d = receiver_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = 4'b0001 << winner;
                    sender_d   = winner;
                    receiver_d = dest_sel;
                    cnt_d      = 8'd1;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req[sender_q] || cnt_q >= HOLD) begin
                    grant_d = 4'b0000;
                    done_d  = 1'b1;
                    last_d  = sender_q;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                state_d = IDLE;
            end
        endcase
        active_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            sender_q   <= 2'd0;
            receiver_q <= 2'd0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 8'd0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sender_q   <= sender_d;
            receiver_q <= receiver_d;
            active_q   <= active_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign grant    = grant_q;
    assign sender   = sender_q;
    assign receiver = receiver_q;
    assign active   = active_q;
    assign done     = done_q;

endmodule
